// File: rtl/stream_demux2_buf_pkg.sv
// stream_demux2_buf_pkg: shared default sizing for the buffered 1-to-2 stream demux.
package stream_demux2_buf_pkg;
  localparam int DEMUX_NBITS_DEFAULT = 4;
  localparam int DEMUX_DEPTH_DEFAULT = 2;
endpackage

// File: rtl/stream_demux2_buf_fifo.sv
// stream_fifo: val/rdy FIFO with separate count so full and empty stay distinct when pointers meet.
module stream_fifo
  import stream_demux2_buf_pkg::*;
#(
  parameter int NBITS = DEMUX_NBITS_DEFAULT,
  parameter int DEPTH = DEMUX_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic [NBITS-1:0] enq_data,
  output logic             full,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [NBITS-1:0] deq_data,
  output logic [CW-1:0]    count
);
  logic [NBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic do_enq, do_deq;
  assign full     = count_q == CW'(DEPTH);
  assign deq_val  = count_q != '0;
  assign deq_data = deq_val ? mem_q[head_q] : '0;
  assign count    = count_q;
  assign do_enq   = enq_val && !full;
  assign do_deq   = deq_val && deq_rdy;
  always_comb begin
    head_d  = do_deq ? head_q + 1'b1 : head_q;
    tail_d  = do_enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(do_enq) - CW'(do_deq);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) mem_q[tail_q] <= enq_data;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/stream_demux2_buf.sv
// stream_demux2_buf: steers one val/rdy stream into two independently buffered outputs by in_sel.
module stream_demux2_buf
  import stream_demux2_buf_pkg::*;
#(
  parameter int NBITS = DEMUX_NBITS_DEFAULT,
  parameter int DEPTH = DEMUX_DEPTH_DEFAULT,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_sel,
  input  logic [NBITS-1:0] in_data,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [NBITS-1:0] out0_data,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [NBITS-1:0] out1_data,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);
  logic full0, full1, acc;
  // Readiness follows the selected side only, so a stalled path never blocks the other.
  assign in_rdy = reset && !(in_sel ? full1 : full0);
  assign acc    = in_val && in_rdy;

  stream_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset),
    .enq_val(acc && !in_sel), .enq_data(in_data), .full(full0),
    .deq_val(out0_val), .deq_rdy(out0_rdy), .deq_data(out0_data), .count(out0_count)
  );

  stream_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset),
    .enq_val(acc && in_sel), .enq_data(in_data), .full(full1),
    .deq_val(out1_val), .deq_rdy(out1_rdy), .deq_data(out1_data), .count(out1_count)
  );
endmodule

// File: tb/tb_stream_demux2_buf.sv
// tb_stream_demux2_buf: directed scenario checks of routing, backpressure, wrap order and async reset.
module tb_stream_demux2_buf;
  logic clk = 0, reset = 0;
  logic in_val = 0, in_rdy, in_sel = 0;
  logic [3:0] in_data = '0;
  logic out0_val, out0_rdy = 0, out1_val, out1_rdy = 0;
  logic [3:0] out0_data, out1_data;
  logic [1:0] out0_count, out1_count;
  int n_vec = 0, n_err = 0;

  stream_demux2_buf dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel), .in_data(in_data),
    .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_data(out0_data),
    .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_data(out1_data),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 0; in_val = 1; in_sel = 0; in_data = 4'hA; out0_rdy = 1; out1_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy: got %b expected 0", in_rdy); end
      n_vec++; if (out0_val !== 1'b0 || out1_val !== 1'b0) begin n_err++; $display("FAIL rst_val: got %b%b expected 00", out0_val, out1_val); end
      n_vec++; if (out0_count !== 2'd0 || out1_count !== 2'd0) begin n_err++; $display("FAIL rst_count: got %0d/%0d expected 0/0", out0_count, out1_count); end
    end
    in_val = 0;
    #2 reset = 1;
    tick();
  endtask

  task automatic test_routing();
    out0_rdy = 1; out1_rdy = 1; in_val = 1; in_sel = 0; in_data = 4'h3;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL route_rdy0: got %b expected 1", in_rdy); end
    n_vec++; if (out0_val !== 1'b0) begin n_err++; $display("FAIL route_no_bypass: got %b expected 0", out0_val); end
    tick();
    in_sel = 1; in_data = 4'h5;
    #1;
    n_vec++; if (out0_val !== 1'b1 || out0_data !== 4'h3) begin n_err++; $display("FAIL route_out0: got %b/%h expected 1/3", out0_val, out0_data); end
    n_vec++; if (out1_val !== 1'b0) begin n_err++; $display("FAIL route_out1_idle: got %b expected 0", out1_val); end
    tick();
    in_val = 0;
    #1;
    n_vec++; if (out0_val !== 1'b0 || out0_data !== 4'h0) begin n_err++; $display("FAIL route_out0_gone: got %b/%h expected 0/0", out0_val, out0_data); end
    n_vec++; if (out1_val !== 1'b1 || out1_data !== 4'h5) begin n_err++; $display("FAIL route_out1: got %b/%h expected 1/5", out1_val, out1_data); end
    tick();
    n_vec++; if (out1_val !== 1'b0) begin n_err++; $display("FAIL route_out1_gone: got %b expected 0", out1_val); end
  endtask

  task automatic test_backpressure();
    out0_rdy = 0; out1_rdy = 0; in_val = 1; in_sel = 0; in_data = 4'h1;
    tick();
    in_data = 4'h2;
    #1;
    chk("bp_count1", {2'b0, out0_count}, 4'd1);
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_half: got %b expected 1", in_rdy); end
    tick();
    chk("bp_count2", {2'b0, out0_count}, 4'd2);
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_full: got %b expected 0", in_rdy); end
    chk("bp_head", out0_data, 4'h1);
    in_sel = 1; in_data = 4'h7;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_other: got %b expected 1", in_rdy); end
    tick();
    in_val = 0;
    #1;
    chk("bp_out1_count", {2'b0, out1_count}, 4'd1);
    chk("bp_out1_data", out1_data, 4'h7);
    chk("bp_out0_untouched", {2'b0, out0_count}, 4'd2);
  endtask

  task automatic test_full_deq();
    in_val = 1; in_sel = 0; in_data = 4'h9; out0_rdy = 1;
    #1;
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL fd_rdy_full: got %b expected 0", in_rdy); end
    tick();
    chk("fd_count", {2'b0, out0_count}, 4'd1);
    chk("fd_head", out0_data, 4'h2);
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL fd_rdy_after: got %b expected 1", in_rdy); end
    in_val = 0; out1_rdy = 1;
    tick();
    chk("fd_drain0", {2'b0, out0_count}, 4'd0);
    chk("fd_drain1", {2'b0, out1_count}, 4'd0);
    n_vec++; if (out0_val !== 1'b0) begin n_err++; $display("FAIL fd_no_enq: got %b expected 0", out0_val); end
  endtask

  task automatic test_wrap();
    int sent = 0, exp_next = 0;
    logic tog = 1;
    in_sel = 0; out1_rdy = 0;
    for (int cyc = 0; cyc < 80 && exp_next < 10; cyc++) begin
      in_val = sent < 10; in_data = 4'(sent); out0_rdy = tog;
      #1;
      if (out0_val && out0_rdy) begin
        chk("wrap_order", out0_data, 4'(exp_next));
        exp_next++;
      end
      if (in_val && in_rdy) sent++;
      n_vec++; if (out0_count > 2'd2) begin n_err++; $display("FAIL wrap_count: got %0d expected <=2", out0_count); end
      tick();
      tog = ~tog;
    end
    in_val = 0; out0_rdy = 0;
    n_vec++; if (exp_next != 10) begin n_err++; $display("FAIL wrap_total: got %0d expected 10", exp_next); end
    #1;
    chk("wrap_empty", {2'b0, out0_count}, 4'd0);
  endtask

  task automatic test_async_reset();
    out1_rdy = 0; in_val = 1; in_sel = 1; in_data = 4'hC;
    tick();
    in_data = 4'hD;
    tick();
    in_val = 0;
    #1;
    chk("ar_count_pre", {2'b0, out1_count}, 4'd2);
    chk("ar_head_pre", out1_data, 4'hC);
    #1 reset = 0;
    #1;
    n_vec++; if (out1_val !== 1'b0) begin n_err++; $display("FAIL ar_val: got %b expected 0", out1_val); end
    chk("ar_count", {2'b0, out1_count}, 4'd0);
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL ar_rdy: got %b expected 0", in_rdy); end
    tick();
    #2 reset = 1;
    tick();
    in_val = 1; in_sel = 1; in_data = 4'h6; out1_rdy = 1;
    tick();
    in_val = 0;
    #1;
    n_vec++; if (out1_val !== 1'b1 || out1_data !== 4'h6) begin n_err++; $display("FAIL ar_new: got %b/%h expected 1/6", out1_val, out1_data); end
    tick();
    n_vec++; if (out1_val !== 1'b0) begin n_err++; $display("FAIL ar_no_stale: got %b/%h expected 0", out1_val, out1_data); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_full_deq();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
